// File: rtl/frame_wr_pkg.sv
// Shared types and helpers for the frame-to-memory burst writer.
// Holds the controller state encoding and the burst-length clamp.
package frame_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CHECK,
    ST_BURST,
    ST_BURST_END,
    ST_DONE
  } state_t;

  function automatic logic [63:0] min_u(input logic [63:0] a, input logic [63:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_buf_sel.sv
// Frame buffer rotation: next index after cur, skipping the reader's buffer.
// sel_index is combinational; cur_index updates on the cycle sel_en is high.
module frame_buf_sel #(
  parameter int NUM_BUFS = 3,
  parameter int IDX_W    = $clog2(NUM_BUFS)
) (
  input  logic             mem_clk,
  input  logic             rst_n,
  input  logic             sel_en,
  input  logic [IDX_W-1:0] rd_buf_index,
  output logic [IDX_W-1:0] sel_index,
  output logic [IDX_W-1:0] cur_index
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BUFS - 1);

  logic [IDX_W-1:0] cur_q;
  logic [IDX_W-1:0] nxt;
  logic [IDX_W-1:0] alt;

  // With two buffers the skip wraps back onto cur, deliberately reusing it.
  always_comb begin
    nxt       = (cur_q == LAST) ? '0 : cur_q + 1'b1;
    alt       = (nxt == LAST) ? '0 : nxt + 1'b1;
    sel_index = (nxt == rd_buf_index) ? alt : nxt;
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      cur_q <= LAST;
    end else if (sel_en) begin
      cur_q <= sel_index;
    end
  end

  assign cur_index = cur_q;

endmodule

// File: rtl/frame_fifo_write_multi.sv
// Drains the capture FIFO into rotating frame buffers via memory bursts; request one cycle after CHECK passes.
// Waits in CHECK until the FIFO holds a full burst; req/len/addr held stable until wr_burst_finish.
module frame_fifo_write_multi
  import frame_wr_pkg::*;
#(
  parameter int ADDR_BITS    = 28,
  parameter int BURST_BITS   = 10,
  parameter int BURST_SIZE   = 128,
  parameter int NUM_BUFS     = 3,
  parameter int CLEAR_CYCLES = 4,
  parameter int IDX_W        = $clog2(NUM_BUFS)
) (
  input  logic                  mem_clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [ADDR_BITS-1:0]  frame_len,
  input  logic [ADDR_BITS-1:0]  base_addr,
  input  logic [ADDR_BITS-1:0]  buf_stride,
  input  logic [IDX_W-1:0]      rd_buf_index,
  input  logic                  proc_ready,
  input  logic [15:0]           fifo_rdusedw,
  output logic                  fifo_aclr,
  output logic                  wr_burst_req,
  output logic [BURST_BITS-1:0] wr_burst_len,
  output logic [ADDR_BITS-1:0]  wr_burst_addr,
  input  logic                  wr_burst_finish,
  output logic                  frame_done,
  output logic [IDX_W-1:0]      done_buf_index,
  output logic                  frame_drop,
  output logic                  busy
);

  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  state_t                state, state_nxt;
  logic [ADDR_BITS-1:0]  len_q, len_d;
  logic [ADDR_BITS-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]  rem;
  logic [BURST_BITS-1:0] blen;
  logic [CLR_W-1:0]      clr_q, clr_d;
  logic                  pending_q, pending_d;
  logic                  aclr_d, req_d, done_d, drop_d;
  logic [BURST_BITS-1:0] blen_d;
  logic [ADDR_BITS-1:0]  addr_d;
  logic [IDX_W-1:0]      didx_d;
  logic                  start_frame;
  logic                  sel_en;
  logic [IDX_W-1:0]      sel_index;
  logic [IDX_W-1:0]      cur_index;

  frame_buf_sel #(
    .NUM_BUFS (NUM_BUFS),
    .IDX_W    (IDX_W)
  ) u_buf_sel (
    .mem_clk      (mem_clk),
    .rst_n        (rst_n),
    .sel_en       (sel_en),
    .rd_buf_index (rd_buf_index),
    .sel_index    (sel_index),
    .cur_index    (cur_index)
  );

  assign rem  = len_q - cnt_q;
  assign blen = BURST_BITS'(min_u(64'(BURST_SIZE), 64'(rem)));
  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    len_d       = len_q;
    cnt_d       = cnt_q;
    clr_d       = clr_q;
    pending_d   = pending_q;
    aclr_d      = fifo_aclr;
    req_d       = wr_burst_req;
    blen_d      = wr_burst_len;
    addr_d      = wr_burst_addr;
    done_d      = 1'b0;
    didx_d      = done_buf_index;
    drop_d      = 1'b0;
    sel_en      = 1'b0;
    start_frame = 1'b0;

    case (state)
      ST_IDLE: begin
        if (frame_start) start_frame = 1'b1;
      end
      ST_CLEAR: begin
        if (frame_start) begin
          start_frame = 1'b1;
        end else if (clr_q == CLR_W'(CLEAR_CYCLES - 1)) begin
          aclr_d    = 1'b0;
          state_nxt = ST_CHECK;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (frame_start) begin
          start_frame = 1'b1;
        end else if (rem == '0) begin
          state_nxt = ST_DONE;
        end else if (32'(fifo_rdusedw) >= 32'(blen)) begin
          blen_d    = blen;
          req_d     = 1'b1;
          state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        // A new frame cannot cut a burst short; remember it for BURST_END.
        if (frame_start) pending_d = 1'b1;
        if (wr_burst_finish) begin
          req_d     = 1'b0;
          cnt_d     = cnt_q + ADDR_BITS'(wr_burst_len);
          addr_d    = wr_burst_addr + ADDR_BITS'(wr_burst_len);
          state_nxt = ST_BURST_END;
        end
      end
      ST_BURST_END: begin
        if (frame_start || pending_q) begin
          start_frame = 1'b1;
        end else if (cnt_q >= len_q) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_CHECK;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Fresh start and mid-frame abort share one path; an abort always reports a drop.
    if (start_frame) begin
      pending_d = 1'b0;
      if (proc_ready) begin
        sel_en    = 1'b1;
        len_d     = frame_len;
        cnt_d     = '0;
        addr_d    = base_addr + buf_stride * ADDR_BITS'(sel_index);
        clr_d     = '0;
        aclr_d    = 1'b1;
        drop_d    = (state != ST_IDLE);
        state_nxt = ST_CLEAR;
      end else begin
        aclr_d    = 1'b0;
        drop_d    = 1'b1;
        state_nxt = ST_IDLE;
      end
    end

    // frame_done is high for exactly the cycle spent in DONE.
    if (state_nxt == ST_DONE && state != ST_DONE) begin
      done_d = 1'b1;
      didx_d = cur_index;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      len_q          <= '0;
      cnt_q          <= '0;
      clr_q          <= '0;
      pending_q      <= 1'b0;
      fifo_aclr      <= 1'b0;
      wr_burst_req   <= 1'b0;
      wr_burst_len   <= '0;
      wr_burst_addr  <= '0;
      frame_done     <= 1'b0;
      done_buf_index <= '0;
      frame_drop     <= 1'b0;
    end else begin
      state          <= state_nxt;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      clr_q          <= clr_d;
      pending_q      <= pending_d;
      fifo_aclr      <= aclr_d;
      wr_burst_req   <= req_d;
      wr_burst_len   <= blen_d;
      wr_burst_addr  <= addr_d;
      frame_done     <= done_d;
      done_buf_index <= didx_d;
      frame_drop     <= drop_d;
    end
  end

endmodule

// File: tb/tb_frame_fifo_write_multi.sv
// Bench for frame_fifo_write_multi: frame table, hand sequences, random frames vs a frame-level model.
module tb_frame_fifo_write_multi;

  localparam int NB = 3;
  localparam int BS = 128;
  localparam logic [27:0] BASE   = 28'h010_0000;
  localparam logic [27:0] STRIDE = 28'h004_0000;

  logic        mem_clk;
  logic        rst_n;
  logic        frame_start;
  logic [27:0] frame_len;
  logic [27:0] base_addr;
  logic [27:0] buf_stride;
  logic [1:0]  rd_buf_index;
  logic        proc_ready;
  logic [15:0] fifo_rdusedw;
  logic        fifo_aclr;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [27:0] wr_burst_addr;
  logic        wr_burst_finish;
  logic        frame_done;
  logic [1:0]  done_buf_index;
  logic        frame_drop;
  logic        busy;

  logic        sb_en;
  logic [0:0]  sb_rd;
  logic [0:0]  sb_sel;
  logic [0:0]  sb_cur;

  frame_fifo_write_multi dut (
    .mem_clk(mem_clk), .rst_n(rst_n), .frame_start(frame_start), .frame_len(frame_len),
    .base_addr(base_addr), .buf_stride(buf_stride), .rd_buf_index(rd_buf_index),
    .proc_ready(proc_ready), .fifo_rdusedw(fifo_rdusedw), .fifo_aclr(fifo_aclr),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_finish(wr_burst_finish), .frame_done(frame_done), .done_buf_index(done_buf_index),
    .frame_drop(frame_drop), .busy(busy)
  );

  frame_buf_sel #(.NUM_BUFS(2), .IDX_W(1)) u_sel2 (
    .mem_clk(mem_clk), .rst_n(rst_n), .sel_en(sb_en), .rd_buf_index(sb_rd),
    .sel_index(sb_sel), .cur_index(sb_cur)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Bus monitor: records bursts and pulses seen since the last clear.
  logic        mon_clr = 1'b0;
  int          cyc = 0, burst_n = 0, done_cnt = 0, drop_cnt = 0, aclr_cycles = 0;
  int          busy_cycles = 0, unstable = 0, gate_bad = 0, done_idx = 0;
  int          fin_cyc = 0, done_cyc = 0;
  logic [27:0] b_addr [16];
  logic [9:0]  b_len  [16];
  logic        prev_req = 1'b0;
  logic [27:0] prev_addr = '0;
  logic [9:0]  prev_len = '0;
  logic [15:0] prev_fifo = '0;

  always @(negedge mem_clk) begin
    cyc = cyc + 1;
    if (mon_clr) begin
      burst_n = 0; done_cnt = 0; drop_cnt = 0; aclr_cycles = 0; busy_cycles = 0;
      unstable = 0; gate_bad = 0; done_idx = 0;
    end else begin
      if (wr_burst_req && !prev_req) begin
        if (burst_n < 16) begin
          b_addr[burst_n] = wr_burst_addr;
          b_len[burst_n]  = wr_burst_len;
        end
        burst_n++;
        if (int'(wr_burst_len) > int'(prev_fifo)) gate_bad++;
      end
      if (wr_burst_req && prev_req && (wr_burst_addr != prev_addr || wr_burst_len != prev_len))
        unstable++;
      if (fifo_aclr) aclr_cycles++;
      if (busy) busy_cycles++;
      if (frame_drop) drop_cnt++;
      if (wr_burst_finish) fin_cyc = cyc;
      if (frame_done) begin
        done_cnt++;
        done_idx = int'(done_buf_index);
        done_cyc = cyc;
      end
    end
    prev_req  = wr_burst_req;
    prev_addr = wr_burst_addr;
    prev_len  = wr_burst_len;
    prev_fifo = fifo_rdusedw;
  end

  // Memory controller: finish pulse mc_lat cycles after a request is seen.
  logic mc_en;
  int   mc_lat;
  initial begin
    wr_burst_finish = 1'b0;
    forever begin
      @(negedge mem_clk);
      if (mc_en && wr_burst_req) begin
        repeat (mc_lat) @(posedge mem_clk);
        @(posedge mem_clk); #1 wr_burst_finish = 1'b1;
        @(posedge mem_clk); #1 wr_burst_finish = 1'b0;
      end
    end
  end

  // FIFO level source: fixed value or random per cycle.
  logic        fifo_mode;
  logic [15:0] fifo_fix;
  initial begin
    fifo_rdusedw = 16'd0;
    forever begin
      @(posedge mem_clk); #1;
      fifo_rdusedw = fifo_mode ? 16'($urandom_range(0, 200)) : fifo_fix;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic bit cond(input int kind);
    case (kind)
      0: return (done_cnt > 0) || (drop_cnt > 0);
      1: return burst_n >= 2;
      2: return wr_burst_req == 1'b1;
      default: return done_cnt > 0;
    endcase
  endfunction

  task automatic wait_cond(input int kind, input int limit, input string nm);
    int t = 0;
    while (!cond(kind) && t < limit) begin
      @(negedge mem_clk); #1;
      t++;
    end
    check({nm, " timeout"}, longint'(t < limit), 1);
  endtask

  task automatic pulse_start(input int len, input int rd, input bit pr, input bit clr);
    @(posedge mem_clk); #1;
    mon_clr = clr; frame_start = 1'b1; frame_len = 28'(len);
    rd_buf_index = 2'(rd); proc_ready = pr;
    @(posedge mem_clk); #1;
    mon_clr = 1'b0; frame_start = 1'b0;
  endtask

  function automatic int pick(input int cur, input int rd);
    int n = (cur + 1) % NB;
    if (n == rd) n = (n + 1) % NB;
    return n;
  endfunction

  task automatic run_frame(input int len, input int rd, input bit pr, input int exp_buf,
                           input int exp_nb, input string nm);
    int lim;
    pulse_start(len, rd, pr, 1'b1);
    wait_cond(0, 6000, nm);
    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk); #1;
    check({nm, " done_cnt"}, done_cnt, pr ? 1 : 0);
    check({nm, " drop_cnt"}, drop_cnt, pr ? 0 : 1);
    check({nm, " bursts"}, burst_n, exp_nb);
    check({nm, " aclr_cycles"}, aclr_cycles, pr ? 4 : 0);
    check({nm, " unstable"}, unstable, 0);
    check({nm, " fifo_gate"}, gate_bad, 0);
    check({nm, " busy_end"}, busy, 0);
    if (pr) check({nm, " done_idx"}, done_idx, exp_buf);
    else    check({nm, " busy_cycles"}, busy_cycles, 0);
    lim = (burst_n < exp_nb) ? burst_n : exp_nb;
    for (int i = 0; i < lim && i < 16; i++) begin
      check($sformatf("%s addr%0d", nm, i), b_addr[i], 28'(BASE + STRIDE * 28'(exp_buf) + 28'(i * BS)));
      check($sformatf("%s len%0d", nm, i), b_len[i], ((len - i * BS) < BS) ? (len - i * BS) : BS);
    end
  endtask

  typedef struct {
    int len;
    int rd;
    bit pr;
    int exp_buf;
    int exp_nb;
  } vec_t;

  vec_t tv [9];
  int   m_cur;

  initial begin
    tv[0] = '{256, 2, 1'b1, 0, 2};
    tv[1] = '{256, 2, 1'b1, 1, 2};
    tv[2] = '{256, 2, 1'b1, 0, 2};
    tv[3] = '{256, 2, 1'b1, 1, 2};
    tv[4] = '{300, 2, 1'b0, -1, 0};
    tv[5] = '{0,   0, 1'b1, 2, 0};
    tv[6] = '{128, 1, 1'b1, 0, 1};
    tv[7] = '{129, 1, 1'b1, 2, 2};
    tv[8] = '{1,   0, 1'b1, 1, 1};

    rst_n = 1'b0; frame_start = 1'b0; frame_len = '0; base_addr = BASE; buf_stride = STRIDE;
    rd_buf_index = 2'd0; proc_ready = 1'b0; mc_en = 1'b1; mc_lat = 1;
    fifo_mode = 1'b0; fifo_fix = 16'd1000; sb_en = 1'b0; sb_rd = 1'b0;
    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk); #1;
    check("rst fifo_aclr", fifo_aclr, 0);
    check("rst wr_burst_req", wr_burst_req, 0);
    check("rst wr_burst_len", wr_burst_len, 0);
    check("rst wr_burst_addr", wr_burst_addr, 0);
    check("rst frame_done", frame_done, 0);
    check("rst frame_drop", frame_drop, 0);
    check("rst done_buf_index", done_buf_index, 0);
    check("rst busy", busy, 0);
    @(posedge mem_clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_frame(tv[i].len, tv[i].rd, tv[i].pr, tv[i].exp_buf, tv[i].exp_nb, $sformatf("tbl%0d", i));

    // Partial final burst stalls until the FIFO holds 44 words; cur=1, rd=2 -> buffer 0.
    mc_lat = 4; fifo_fix = 16'd128;
    pulse_start(300, 2, 1'b1, 1'b1);
    @(negedge mem_clk); #1;
    check("p300 aclr_next", fifo_aclr, 1);
    check("p300 busy_next", busy, 1);
    wait_cond(1, 2000, "p300 two_bursts");
    fifo_fix = 16'd43;
    repeat (30) @(posedge mem_clk);
    @(negedge mem_clk); #1;
    check("p300 stalled_bursts", burst_n, 2);
    check("p300 stalled_req", wr_burst_req, 0);
    fifo_fix = 16'd44;
    wait_cond(3, 200, "p300 done");
    check("p300 last_len", b_len[2], 44);
    check("p300 last_addr", b_addr[2], BASE + 28'd256);
    check("p300 done_idx", done_idx, 0);
    check("p300 done_latency", done_cyc - fin_cyc, 2);
    check("p300 bursts", burst_n, 3);

    // New frame during the second burst of a 512-word frame in buffer 1.
    mc_lat = 8; fifo_fix = 16'd1000;
    pulse_start(512, 2, 1'b1, 1'b1);
    wait_cond(1, 2000, "abort second_burst");
    pulse_start(128, 2, 1'b1, 1'b0);
    wait_cond(3, 2000, "abort new_done");
    repeat (3) @(posedge mem_clk);
    @(negedge mem_clk); #1;
    check("abort drop_cnt", drop_cnt, 1);
    check("abort done_cnt", done_cnt, 1);
    check("abort done_idx", done_idx, 0);
    check("abort bursts", burst_n, 3);
    check("abort burst1_addr", b_addr[1], BASE + STRIDE + 28'd128);
    check("abort burst1_len", b_len[1], 128);
    check("abort new_addr", b_addr[2], BASE);
    check("abort aclr_cycles", aclr_cycles, 8);

    // Reset while a request is outstanding.
    mc_en = 1'b0; mc_lat = 1;
    pulse_start(256, 2, 1'b1, 1'b1);
    wait_cond(2, 200, "rst_mid req");
    @(posedge mem_clk); #1 rst_n = 1'b0;
    @(posedge mem_clk);
    @(negedge mem_clk); #1;
    check("rst_mid req", wr_burst_req, 0);
    check("rst_mid len", wr_burst_len, 0);
    check("rst_mid addr", wr_burst_addr, 0);
    check("rst_mid aclr", fifo_aclr, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid done", frame_done, 0);
    check("rst_mid drop", frame_drop, 0);
    @(posedge mem_clk); #1 rst_n = 1'b1; mc_en = 1'b1;
    m_cur = NB - 1;
    m_cur = pick(m_cur, 2);
    run_frame(256, 2, 1'b1, m_cur, 2, "post_rst");
    check("post_rst buffer0", m_cur, 0);

    // Random frames against the frame-level model.
    fifo_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int len, rd;
      bit pr;
      len    = $urandom_range(0, 600);
      rd     = $urandom_range(0, NB - 1);
      pr     = ($urandom_range(0, 7) != 0);
      mc_lat = $urandom_range(0, 3);
      if (pr) m_cur = pick(m_cur, rd);
      run_frame(len, rd, pr, pr ? m_cur : -1, pr ? (len + BS - 1) / BS : 0, $sformatf("rnd%0d", k));
    end
    fifo_mode = 1'b0;

    // Two-buffer selector: cur=0 with reader on 1 reuses buffer 0.
    @(negedge mem_clk); #1;
    check("sel2 rst_cur", sb_cur, 1);
    sb_rd = 1'b1; sb_en = 1'b1;
    @(posedge mem_clk); #1 sb_en = 1'b0;
    @(negedge mem_clk); #1;
    check("sel2 cur0", sb_cur, 0);
    check("sel2 reuse_sel", sb_sel, 0);
    sb_en = 1'b1;
    @(posedge mem_clk); #1 sb_en = 1'b0;
    @(negedge mem_clk); #1;
    check("sel2 reuse_cur", sb_cur, 0);
    sb_rd = 1'b0;
    #1;
    check("sel2 skip_sel", sb_sel, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
